scaler_multi: RTL
=================

Name: scaler_multi

Overview:
Multi-channel programmable clock scaler. It is the parametrised successor to the fixed-N single-output scaler. Each channel divides clk_in by a divisor that can be changed at runtime. Each channel produces a near-50% square wave and a one-cycle tick strobe. Divisor changes take effect glitch-free at period boundaries. The block sits between the board clock and the slow peripherals (UART baud, LED PWM, debouncers) that need clock enables.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
WIDTH, 16, divisor/counter width in bits
DEFAULT_DIV, 10, divisor loaded into every channel at reset (must be >= 2 and < 2**WIDTH)

Ports:
clk_in  input  1  sole clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
div_wr  input  1  single-cycle strobe; writes div_value into the channel selected by div_sel
div_sel  input  $clog2(CHANNELS) (min 1)  channel index for div_wr
div_value  input  WIDTH  new divisor D
enable  input  CHANNELS  per-channel run enable
clk_out  output  CHANNELS  per-channel divided square wave, registered
tick  output  CHANNELS  per-channel one-cycle strobe per output period, registered

Behaviour:
- Reset (async assert, sync-safe deassert is not required inside the block):
  - count=0, active_div=DEFAULT_DIV, pending_div=DEFAULT_DIV, pending_valid=0.
  - clk_out=0, tick=0 for all channels.
- Per channel, with effective divisor E = max(active_div, 2). Values 0 and 1 are clamped to 2.
- Running (enable=1): count steps 0,1,..,E-1, then wraps to 0. One output period is E clk_in cycles.
- clk_out register: next value is 1 when the next count < ceil(E/2), else 0.
  - Result: high for ceil(E/2) cycles, low for floor(E/2) cycles.
  - E=10 gives 5 high / 5 low. E=3 gives 2 high / 1 low.
- tick register: high for exactly one cycle, in the cycle after count==E-1. This aligns with clk_out's rising edge.
- Latency: after enable rises (sampled at edge k), clk_out=1 and count=1 at edge k+1. The first tick follows E cycles later.
- Divisor write: div_wr=1 loads pending_div and sets pending_valid for the channel div_sel.
  - An out-of-range div_sel (>= CHANNELS) is ignored.
  - Back-to-back writes to the same channel: the last write before the boundary wins.
- Apply rule:
  - Running: pending_div is copied to active_div on the wrap edge (count E-1 -> 0), and pending_valid clears. The current period always completes with the old divisor, so there are no runt pulses.
  - Disabled: pending_div is applied on the next edge.
  - A write coinciding with the wrap edge is applied at the following wrap, not the current one.
- Disable (enable=0) mid-period: on the next edge, count=0, clk_out=0, tick=0; the counter is held. Re-enabling restarts from phase 0.
- Channels are fully independent; simultaneous div_wr and enable changes on other channels do not interact.
- Reset mid-period: all state returns to reset values immediately; pending writes are discarded.

Optional Feature:
SCALER_PHASE_SYNC_EN
- Defined: adds input port phase_sync (1 bit). phase_sync=1 forces count=0, clk_out=0, tick=0 on the next edge for every enabled channel, and applies any pending divisors. Channels then restart together, so divisors that are integer multiples stay phase-aligned. phase_sync has priority over wrap and div_wr apply.
- Undefined: no phase_sync port; the only phase alignment comes from reset and enable.

Decomposition:
- Package scaler_pkg:
  - MIN_DIV=2.
  - Function for ceil(E/2) high-time.
  - Function for safe $clog2 (returns at least 1).
- Sub-module scaler_chan: one channel containing counter, active/pending divisor, and clk_out/tick registers.
- scaler_multi:
  - Decodes div_wr/div_sel into per-channel write strobes.
  - Instantiates CHANNELS copies of scaler_chan in a generate loop.

Test Plan:
- Reset with DEFAULT_DIV=10, enable=all-1, run 200 ns at 10 ns clk -> each clk_out period 100 ns, 50 ns high; tick pulses every 10 cycles, coincident with clk_out rise.
- Odd divisor: write D=3 to ch1 while disabled, then enable -> clk_out pattern 1,1,0 repeating; tick every 3 cycles.
- Mid-period change: ch0 running D=10, write D=4 at count=3 -> remaining 6 cycles keep the D=10 waveform; the next period is 4 cycles (2 high, 2 low), with no runt pulse.
- Clamp/invalid: write D=0 and D=1 to ch2 -> behaves as D=2 (toggle every cycle); write with div_sel=7 when CHANNELS=4 -> no channel changes.
- Disable/re-enable and reset: drop enable ch3 at count=5 -> clk_out=0 next edge and held; re-enable -> restart at phase 0. Assert reset mid-period -> outputs 0 immediately; divisors return to 10.
- With SCALER_PHASE_SYNC_EN: ch0 D=4, ch1 D=8 with skewed phase; pulse phase_sync -> both rise on the same edge; ch1 rising edges coincide with every second ch0 rising edge.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared constants and helpers for the multi-channel clock scaler.
// Used by scaler_chan and scaler_multi.
package scaler_pkg;

    localparam int MIN_DIV = 2;

    function automatic int unsigned high_time(input int unsigned e);
        return (e + 1) / 2;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scaler_chan.sv
// One divider channel: counter, active/pending divisor, clk_out and tick.
// Divisor updates land only on period boundaries or while idle.
module scaler_chan
    import scaler_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_value,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] half;
    logic             wrap;
    logic             apply;

    always_comb begin
        eff = (active_q < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : active_q;
        half = WIDTH'(high_time(32'(eff)));
        wrap = (count_q == eff - 1'b1);
        count_d = count_q;
        active_d = active_q;
        pending_d = pending_q;
        pending_valid_d = pending_valid_q;
        clk_out_d = 1'b0;
        tick_d = 1'b0;
        apply = 1'b0;
        if (sync && enable) begin
            count_d = '0;
            apply = 1'b1;
        end else if (enable) begin
            count_d = wrap ? '0 : count_q + 1'b1;
            clk_out_d = (count_d < half);
            tick_d = wrap;
            apply = wrap;
        end else begin
            count_d = '0;
            apply = 1'b1;
        end
        if (apply && pending_valid_q) begin
            active_d = pending_q;
            pending_valid_d = 1'b0;
        end
        // A write on the apply edge waits for the next boundary.
        if (wr) begin
            pending_d = wr_value;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            active_q <= WIDTH'(DEFAULT_DIV);
            pending_q <= WIDTH'(DEFAULT_DIV);
            pending_valid_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            count_q <= count_d;
            active_q <= active_d;
            pending_q <= pending_d;
            pending_valid_q <= pending_valid_d;
            clk_out_q <= clk_out_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick = tick_q;

endmodule

// File: rtl/scaler_multi.sv
// Multi-channel programmable clock scaler; optional SCALER_PHASE_SYNC_EN
// adds a phase_sync input that restarts all enabled channels together.
module scaler_multi
    import scaler_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                                clk_in,
    input  logic                                reset,
`ifdef SCALER_PHASE_SYNC_EN
    input  logic                                phase_sync,
`endif
    input  logic                                div_wr,
    input  logic [clog2_min1(CHANNELS)-1:0]     div_sel,
    input  logic [WIDTH-1:0]                    div_value,
    input  logic [CHANNELS-1:0]                 enable,
    output logic [CHANNELS-1:0]                 clk_out,
    output logic [CHANNELS-1:0]                 tick
);

    localparam int SW = clog2_min1(CHANNELS);

    logic [CHANNELS-1:0] wr_hit;
    logic                sync_all;

`ifdef SCALER_PHASE_SYNC_EN
    assign sync_all = phase_sync;
`else
    assign sync_all = 1'b0;
`endif

    // Out-of-range selects match no channel and are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = div_wr && (div_sel == SW'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        scaler_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in   (clk_in),
            .reset    (reset),
            .enable   (enable[g]),
            .sync     (sync_all),
            .wr       (wr_hit[g]),
            .wr_value (div_value),
            .clk_out  (clk_out[g]),
            .tick     (tick[g])
        );
    end

endmodule
